// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller.
// Responds to the I-cache block-fetch handshake and the load/store-buffer
// data handshake, and owns the 8-bit unified RAM/IO bus. One transaction at
// a time; the LSB takes priority over the I-cache.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = hold everything)
//   mem_din / mem_dout / mem_a / mem_wr       : byte bus to RAM/IO
//   io_buffer_full                            : IO output buffer full
//   IC2MC_en / IC2MC_addr                     : block request (level)
//   MC2IC_en / MC2IC_block                    : block response pulse + data
//   LSB2MC_en/_wr/_len/_addr/_data            : load/store request (level)
//   MC2LSB_en / MC2LSB_data                   : done pulse + load data
//   ROB2MC_pre_judge                          : low = misprediction flush
//
// state    | meaning
// IDLE     | sample requests (LSB first, then I-cache)
// IC_READ  | reading NB bytes of an instruction block
// LS_READ  | reading n bytes of a load
// LS_WRITE | writing n bytes of a store
// RESP     | response pulse high; ignore stale request levels
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 1,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    IC2MC_en,
    input  logic [ADDR_WIDTH-1:0]   IC2MC_addr,
    output logic                    MC2IC_en,
    output logic [32*BLOCK_SIZE-1:0] MC2IC_block,
    input  logic                    LSB2MC_en,
    input  logic                    LSB2MC_wr,
    input  logic [1:0]              LSB2MC_len,
    input  logic [ADDR_WIDTH-1:0]   LSB2MC_addr,
    input  logic [31:0]             LSB2MC_data,
    output logic                    MC2LSB_en,
    output logic [31:0]             MC2LSB_data,
    input  logic                    ROB2MC_pre_judge
);
    localparam int NB    = 4 * BLOCK_SIZE;
    localparam int BW    = 32 * BLOCK_SIZE;
    localparam int CNT_W = BLOCK_WIDTH + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

    typedef enum logic [2:0] {IDLE, IC_READ, LS_READ, LS_WRITE, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [ADDR_WIDTH-1:0]  base_q, base_d, mem_a_d;
    logic [2:0]             n_q, n_d, req_n;
    logic [31:0]            wdata_q, wdata_d;
    logic [BW-1:0]          buf_q, buf_d, buf_fill;
    logic [7:0]             mem_dout_d;
    logic                   mem_wr_d, ic_en_d, lsb_en_d;
    logic [BW-1:0]          ic_block_d;
    logic [31:0]            lsb_data_d;
    logic                   store_blocked;

    assign cnt_inc = cnt_q + 1'b1;

    // A store to IO space must wait for room in the IO buffer.
    assign store_blocked = LSB2MC_wr && (LSB2MC_addr[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        case (LSB2MC_len)
            2'd0:    req_n = 3'd1;
            2'd1:    req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    // Working buffer with the current RAM byte dropped into slot cnt.
    always_comb begin
        buf_fill = buf_q;
        buf_fill[{cnt_q, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        n_d        = n_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        mem_wr_d   = mem_wr;
        ic_en_d    = MC2IC_en;
        lsb_en_d   = MC2LSB_en;
        ic_block_d = MC2IC_block;
        lsb_data_d = MC2LSB_data;

        // A flush kills a load even while the bus is stalled.
        if (!ROB2MC_pre_judge && state_q == LS_READ) begin
            state_d = IDLE;
            cnt_d   = '0;
            mem_a_d = '0;
        end else if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (ROB2MC_pre_judge) begin
                        if (LSB2MC_en) begin
                            // A blocked store keeps the bus; the I-cache waits too.
                            if (!store_blocked) begin
                                base_d  = LSB2MC_addr;
                                n_d     = req_n;
                                wdata_d = LSB2MC_data;
                                buf_d   = '0;
                                mem_a_d = LSB2MC_addr;
                                if (LSB2MC_wr) begin
                                    state_d    = LS_WRITE;
                                    mem_wr_d   = 1'b1;
                                    mem_dout_d = LSB2MC_data[7:0];
                                    cnt_d      = CNT_W'(1);
                                end else begin
                                    state_d = LS_READ;
                                    cnt_d   = '0;
                                end
                            end
                        end else if (IC2MC_en) begin
                            state_d = IC_READ;
                            base_d  = IC2MC_addr;
                            buf_d   = '0;
                            mem_a_d = IC2MC_addr;
                            cnt_d   = '0;
                        end
                    end
                end
                IC_READ: begin
                    buf_d = buf_fill;
                    if (cnt_q == CNT_LAST) begin
                        ic_block_d = buf_fill;
                        ic_en_d    = 1'b1;
                        state_d    = RESP;
                        cnt_d      = '0;
                        mem_a_d    = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        mem_a_d = base_q + ADDR_WIDTH'(cnt_inc);
                    end
                end
                LS_READ: begin
                    buf_d = buf_fill;
                    if (cnt_inc == CNT_W'(n_q)) begin
                        lsb_data_d = buf_fill[31:0];
                        lsb_en_d   = 1'b1;
                        state_d    = RESP;
                        cnt_d      = '0;
                        mem_a_d    = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        mem_a_d = base_q + ADDR_WIDTH'(cnt_inc);
                    end
                end
                LS_WRITE: begin
                    if (cnt_q == CNT_W'(n_q)) begin
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                        lsb_en_d   = 1'b1;
                        state_d    = RESP;
                        cnt_d      = '0;
                    end else begin
                        mem_a_d    = base_q + ADDR_WIDTH'(cnt_q);
                        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d      = cnt_inc;
                    end
                end
                RESP: begin
                    ic_en_d  = 1'b0;
                    lsb_en_d = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            n_q         <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr      <= 1'b0;
            MC2IC_en    <= 1'b0;
            MC2LSB_en   <= 1'b0;
            MC2IC_block <= '0;
            MC2LSB_data <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            n_q         <= n_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_a       <= mem_a_d;
            mem_dout    <= mem_dout_d;
            mem_wr      <= mem_wr_d;
            MC2IC_en    <= ic_en_d;
            MC2LSB_en   <= lsb_en_d;
            MC2IC_block <= ic_block_d;
            MC2LSB_data <= lsb_data_d;
        end
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller: the responder side of the instruction-cache block-fetch handshake and of the load/store-buffer data handshake. It owns the 8-bit unified RAM/IO bus. It assembles little-endian instruction blocks for the I-cache, and performs byte/half/word loads and stores for the LSB. One transaction is in flight at a time. The LSB has priority over the I-cache.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width.
- BLOCK_WIDTH, 1, log2 of words per I-cache block.
- BLOCK_SIZE, 1<<BLOCK_WIDTH, words per block; block bytes NB = 4*BLOCK_SIZE.

Ports:
- clk_in  in  1  clock; all logic on posedge.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  when low, all state and outputs hold.
- mem_din  in  8  RAM read byte; valid the cycle after mem_a is driven.
- mem_dout  out  8  write byte.
- mem_a  out  ADDR_WIDTH  byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  IO output buffer full.
- IC2MC_en  in  1  block request; level, held until MC2IC_en is seen.
- IC2MC_addr  in  ADDR_WIDTH  block-aligned address.
- MC2IC_en  out  1  one-cycle response pulse.
- MC2IC_block  out  32*BLOCK_SIZE  block data; byte k at bits [8k+7:8k].
- LSB2MC_en  in  1  data request; level, held until MC2LSB_en is seen.
- LSB2MC_wr  in  1  1 = store.
- LSB2MC_len  in  2  0 byte, 1 half, 2 word; n = 1, 2 or 4 bytes.
- LSB2MC_addr  in  ADDR_WIDTH  byte address.
- LSB2MC_data  in  32  store data, low n bytes used.
- MC2LSB_en  out  1  one-cycle done pulse.
- MC2LSB_data  out  32  load data, zero-extended above n bytes.
- ROB2MC_pre_judge  in  1  low = misprediction flush.

## Operation
- States:
  - IDLE
  - IC_READ
  - LS_READ
  - LS_WRITE
  - RESP
- A byte counter cnt runs 0..NB. Requests are latched at acceptance.
- IDLE: requests are sampled only here.
  - Accept LSB2MC_en first, otherwise IC2MC_en.
  - A store to IO space (addr[17:16]==2'b11) is not accepted while io_buffer_full=1. It stays pending, and the I-cache is not served in its place.
- IC_READ:
  - Acceptance edge drives mem_a=base, cnt=0.
  - Each following edge captures mem_din into byte cnt, increments cnt, and drives mem_a=base+cnt.
  - The edge capturing byte NB-1 asserts MC2IC_en and enters RESP.
- LS_READ: same procedure with n bytes into MC2LSB_data (upper bytes zero); completes with MC2LSB_en.
- LS_WRITE:
  - Acceptance edge drives mem_wr=1, mem_a=addr, mem_dout=data[7:0].
  - Edge k (k<n) drives byte k at addr+k.
  - Edge n drops mem_wr, sets mem_a=0, asserts MC2LSB_en and enters RESP.
- RESP: next edge clears the pulse and returns to IDLE. This guards against stale request levels, since requesters drop en one edge after the pulse.
- Flush (ROB2MC_pre_judge=0, checked before rdy-gated logic):
  - LS_READ: aborts to IDLE, no MC2LSB_en.
  - IDLE: accepts nothing that edge.
  - IC_READ: not aborted. It completes and pulses MC2IC_en; the I-cache discards that block.
  - LS_WRITE and RESP: unaffected; stores are committed.
- Addresses wrap modulo 2^ADDR_WIDTH. Misaligned loads and stores are performed bytewise as given.

## Timing
- Reset values: every output 0, state IDLE, cnt 0.
- mem_wr is 1 only in LS_WRITE.
- Latency from acceptance edge E to response pulse:
  - Block: NB edges (8 for the default). MC2IC_en is high in the cycle after E+NB.
  - Load or store: n edges.
- Earliest re-acceptance is edge E+NB+2 (or E+n+2).
- MC2IC_block and MC2LSB_data hold their values until the next transaction of the same kind completes.
- Simultaneous IC and LSB requests in IDLE: LSB served; IC is taken at the next IDLE sample.
- rdy_in low mid-transaction freezes cnt, mem_a and mem_wr. The RAM byte is re-read on resume.

## Test plan
- Directed scenarios:
  - Block fetch: RAM[0x100..0x107] = 13 05 00 00 93 05 10 00, IC2MC_addr=0x100 -> after 8 edges, one-cycle MC2IC_en with MC2IC_block=0x0010059300000513. mem_a steps 0x100..0x107; mem_wr stays 0.
  - Loads from 0x200 holding EF BE AD DE: word load -> MC2LSB_data=0xDEADBEEF after 4 edges. Half load at 0x202 -> 0x0000DEAD after 2 edges.
  - Store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr until it drops. Then exactly one write cycle, then MC2LSB_en.
  - IC and LSB word load asserted the same cycle -> load finishes first (4 edges). Block fetch starts no earlier than 2 edges after MC2LSB_en.
  - Flush during a load at cnt=2 -> no MC2LSB_en, back to IDLE.
  - Flush during a block fetch -> fetch still completes with MC2IC_en after 8 edges.
- Reset checks:
  - rst_in=0 mid-store -> all outputs 0 on the next edge, including mem_wr.
  - rdy_in low 3 cycles mid-fetch -> block still correct.
